// File: rtl/mul_tree_issue.sv
// mul_tree_issue: two-stage issue/retire wrapper around an external 32x32
// combinational carry-save tree multiplier. Stage 1 registers unsigned operand
// magnitudes onto the multiplier inputs. Stage 2 captures the unsigned product
// one cycle later, restores the sign and returns it with its tag. Both ends use
// valid/ready handshakes and the pipeline sustains one result per cycle.
module mul_tree_issue #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_signed,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid;
    logic             s1_neg;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_valid;

    logic             accept;
    logic             s2_load;
    logic             out_fire;

    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic             neg_in;
    logic [63:0]      signed_p;

    // Operand magnitudes and result sign; 0x80000000 maps to itself, which
    // the unsigned tree handles correctly.
    always_comb begin
        mag_a  = (in_signed & in_a[31]) ? (~in_a + 32'd1) : in_a;
        mag_b  = (in_signed & in_b[31]) ? (~in_b + 32'd1) : in_b;
        neg_in = in_signed & (in_a[31] ^ in_b[31]);
    end

    // Sign restoration of the tree output; a zero product stays zero.
    always_comb begin
        signed_p = s1_neg ? (~mul_c + 64'd1) : mul_c;
    end

    // Stage 2 loads whenever stage 1 holds work and the output slot is free
    // or being emptied this cycle; stage 1 frees up in the same case.
    assign s2_load   = s1_valid & (~s2_valid | out_ready);
    assign in_ready  = ~s1_valid | s2_load;
    assign accept    = in_valid & in_ready;
    assign out_fire  = s2_valid & out_ready;
    assign out_valid = s2_valid;

    // Stage 1: operand register driving the multiplier, held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_tag   <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
        end else begin
            s1_valid <= accept | (s1_valid & ~s2_load);
            if (accept) begin
                mul_a  <= mag_a;
                mul_b  <= mag_b;
                s1_neg <= neg_in;
                s1_tag <= in_tag;
            end
        end
    end

    // Stage 2: result register, stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_p    <= '0;
            out_tag  <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                out_p    <= signed_p;
                out_tag  <= s1_tag;
            end else if (out_fire) begin
                s2_valid <= 1'b0;
            end
        end
    end

    // Completed-operation counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (out_fire) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mul_tree_issue.sv
// tb_mul_tree_issue: scoreboard bench for mul_tree_issue. A reference tree
// multiplier closes the mul_a/mul_b -> mul_c loop; a second instance with a
// 3-bit counter exercises counter wrap-around.
module tb_mul_tree_issue;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic             in_signed = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_ready = 1'b1;

    logic             in_ready;
    logic [31:0]      mul_a, mul_b;
    logic [63:0]      mul_c;
    logic             out_valid;
    logic [63:0]      out_p;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      op_count;

    logic             in_ready_w;
    logic [31:0]      mul_a_w, mul_b_w;
    logic [63:0]      mul_c_w;
    logic             out_valid_w;
    logic [63:0]      out_p_w;
    logic [TAG_W-1:0] out_tag_w;
    logic [2:0]       op_count_w;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [63:0]      exp_q[$];
    logic [TAG_W-1:0] tag_q[$];
    logic [63:0]      mon_p;
    logic [TAG_W-1:0] mon_t;

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference tree multipliers: plain unsigned 32x32 products.
    assign mul_c   = {32'd0, mul_a} * {32'd0, mul_b};
    assign mul_c_w = {32'd0, mul_a_w} * {32'd0, mul_b_w};

    mul_tree_issue #(.TAG_W(TAG_W), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_tag(out_tag), .op_count(op_count)
    );

    mul_tree_issue #(.TAG_W(TAG_W), .CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
        .mul_a(mul_a_w), .mul_b(mul_b_w), .mul_c(mul_c_w),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_p(out_p_w),
        .out_tag(out_tag_w), .op_count(op_count_w)
    );

    // Golden product computed with 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        longint sa, sb;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Scoreboard: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL scoreboard_extra: got p=%h tag=%0d, required no result",
                         out_p, out_tag);
            end else begin
                mon_p = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                if (out_p !== mon_p || out_tag !== mon_t)
                    $display("[TB] FAIL scoreboard_result: got p=%h tag=%0d, required p=%h tag=%0d",
                             out_p, out_tag, mon_p, mon_t);
                else
                    pass_cnt++;
            end
        end
    end

    // Present one request and wait (bounded) until it is accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input logic [TAG_W-1:0] tag, output int waited);
        bit done;
        done = 1'b0;
        waited = -1;
        in_a = a; in_b = b; in_signed = sgn; in_tag = tag; in_valid = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b, sgn));
                tag_q.push_back(tag);
                @(posedge clk); #1;
                waited = c;
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            total_cnt++;
            $display("[TB] FAIL send_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
        end
    endtask

    // Wait (bounded) until the scoreboard is empty and the output idle.
    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
        end
        total_cnt++;
        if (!done) $display("[TB] FAIL drain: %0d results outstanding, required 0", exp_q.size());
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_q.delete();
        tag_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_p !== 64'd0 || out_tag !== '0 || op_count !== 32'd0)
            $display("[TB] FAIL reset_outputs: valid=%b p=%h tag=%0d cnt=%0d, required 0/0/0/0",
                     out_valid, out_p, out_tag, op_count);
        else pass_cnt++;
        total_cnt++;
        if (mul_a !== 32'd0 || mul_b !== 32'd0 || in_ready !== 1'b1)
            $display("[TB] FAIL reset_stage1: a=%h b=%h in_ready=%b, required 0/0/1",
                     mul_a, mul_b, in_ready);
        else pass_cnt++;
        do_reset();
    endtask

    task automatic test_unsigned();
        int w;
        do_reset();
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'd3, w);
        total_cnt++;
        if (w !== 0 || out_valid !== 1'b0)
            $display("[TB] FAIL unsigned_accept: wait=%0d out_valid=%b, required 0/0", w, out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (out_valid !== 1'b1 || out_p !== 64'hFFFFFFFE00000001 || out_tag !== 4'd3)
            $display("[TB] FAIL unsigned_result: valid=%b p=%h tag=%0d, required 1/fffffffe00000001/3",
                     out_valid, out_p, out_tag);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (op_count !== 32'd1 || out_valid !== 1'b0)
            $display("[TB] FAIL unsigned_count: cnt=%0d valid=%b, required 1/0", op_count, out_valid);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        int w;
        do_reset();
        send(32'hFFFFFFFD, 32'd5, 1'b1, 4'd1, w);
        total_cnt++;
        if (mul_a !== 32'd3 || mul_b !== 32'd5)
            $display("[TB] FAIL signed_magnitude: a=%h b=%h, required 3/5", mul_a, mul_b);
        else pass_cnt++;
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'd2, w);
        send(32'h80000000, 32'h80000000, 1'b1, 4'd3, w);
        total_cnt++;
        if (mul_a !== 32'h80000000 || mul_b !== 32'h80000000)
            $display("[TB] FAIL signed_min_magnitude: a=%h b=%h, required 80000000", mul_a, mul_b);
        else pass_cnt++;
        send(32'd0, 32'hFFFFFFF9, 1'b1, 4'd4, w);
        drain();
        total_cnt++;
        if (op_count !== 32'd4)
            $display("[TB] FAIL signed_count: cnt=%0d, required 4", op_count);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int w, max_w;
        do_reset();
        max_w = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'(i), 32'(i + 1), 1'b0, TAG_W'(i), w);
            if (w != 0) max_w = (w < 0) ? 99 : w;
        end
        total_cnt++;
        if (max_w != 0)
            $display("[TB] FAIL stream_in_ready: stall=%0d cycles, required 0", max_w);
        else pass_cnt++;
        repeat (2) begin @(posedge clk); #1; end
        total_cnt++;
        if (op_count !== 32'd8)
            $display("[TB] FAIL stream_throughput: cnt=%0d, required 8", op_count);
        else pass_cnt++;
        drain();
    endtask

    task automatic test_backpressure();
        int w0, w1, w2;
        logic [63:0] first_p;
        do_reset();
        out_ready = 1'b0;
        first_p = model(32'd1000, 32'd2000, 1'b0);
        send(32'd1000, 32'd2000, 1'b0, 4'd10, w0);
        send(32'hFFFFFFF6, 32'd7, 1'b1, 4'd11, w1);
        total_cnt++;
        if (w0 !== 0 || w1 !== 0)
            $display("[TB] FAIL bp_first_two: waits=%0d/%0d, required 0/0", w0, w1);
        else pass_cnt++;
        in_a = 32'd12345; in_b = 32'd678; in_signed = 1'b0; in_tag = 4'd12; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_p !== first_p || out_tag !== 4'd10)
                $display("[TB] FAIL bp_stall: in_ready=%b valid=%b p=%h tag=%0d, required 0/1/%h/10",
                         in_ready, out_valid, out_p, out_tag, first_p);
            else pass_cnt++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'd12345, 32'd678, 1'b0, 4'd12, w2);
        drain();
        total_cnt++;
        if (op_count !== 32'd3)
            $display("[TB] FAIL bp_count: cnt=%0d, required 3", op_count);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int w;
        do_reset();
        send(32'd9, 32'd9, 1'b0, 4'd5, w);
        repeat (2) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        send(32'd21, 32'd22, 1'b0, 4'd6, w);
        send(32'd23, 32'd24, 1'b0, 4'd7, w);
        total_cnt++;
        if (out_valid !== 1'b1 || op_count !== 32'd1)
            $display("[TB] FAIL midrst_setup: valid=%b cnt=%0d, required 1/1", out_valid, op_count);
        else pass_cnt++;
        rst_n = 1'b0;
        exp_q.delete();
        tag_q.delete();
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || out_p !== 64'd0 || mul_a !== 32'd0 || mul_b !== 32'd0 ||
            op_count !== 32'd0)
            $display("[TB] FAIL midrst_async: valid=%b p=%h a=%h b=%h cnt=%0d, required all 0",
                     out_valid, out_p, mul_a, mul_b, op_count);
        else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL midrst_release: in_ready=%b valid=%b, required 1/0", in_ready, out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        send(32'hFFFFFFFE, 32'd50, 1'b1, 4'd8, w);
        drain();
        total_cnt++;
        if (op_count !== 32'd1)
            $display("[TB] FAIL midrst_count: cnt=%0d, required 1", op_count);
        else pass_cnt++;
    endtask

    task automatic test_counter_wrap();
        int w;
        logic [2:0] want;
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send(32'(i), 32'd3, 1'b0, TAG_W'(i), w);
            repeat (2) begin @(posedge clk); #1; end
            want = 3'(i % 8);
            total_cnt++;
            if (op_count_w !== want)
                $display("[TB] FAIL wrap_count_%0d: cnt=%0d, required %0d", i, op_count_w, want);
            else pass_cnt++;
        end
        drain();
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
